// File: rtl/tick_timer_bank_if.sv
// tick_timer_bank_if
// Bundles the configuration, control and status signals of tick_timer_bank.
//   prescale_i : shared prescaler divider (step every prescale_i+1 clocks)
//   period_i   : per-channel period, channel c in [c*WIDTH +: WIDTH]
//   enable_i   : per-channel enable level
//   oneshot_i  : per-channel mode, 1 = one-shot, 0 = periodic
//   start_i    : per-channel one-shot trigger
//   clear_i    : per-channel sticky flag clear
//   tick_o     : registered single-cycle terminal-count pulse
//   toggle_o   : registered square wave, inverts on every tick
//   flag_o     : sticky "tick occurred"
//   busy_o     : channel currently counting
// master drives configuration/control, slave (the timer bank) drives status.
interface tick_timer_bank_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 24,
    parameter int PW       = 8
);
    logic [PW-1:0]             prescale_i;
    logic [CHANNELS*WIDTH-1:0] period_i;
    logic [CHANNELS-1:0]       enable_i;
    logic [CHANNELS-1:0]       oneshot_i;
    logic [CHANNELS-1:0]       start_i;
    logic [CHANNELS-1:0]       clear_i;
    logic [CHANNELS-1:0]       tick_o;
    logic [CHANNELS-1:0]       toggle_o;
    logic [CHANNELS-1:0]       flag_o;
    logic [CHANNELS-1:0]       busy_o;

    modport master (
        output prescale_i, period_i, enable_i, oneshot_i, start_i, clear_i,
        input  tick_o, toggle_o, flag_o, busy_o
    );

    modport slave (
        input  prescale_i, period_i, enable_i, oneshot_i, start_i, clear_i,
        output tick_o, toggle_o, flag_o, busy_o
    );
endinterface

// File: rtl/tick_timer_bank.sv
// tick_timer_bank
// Multi-channel programmable tick generator. A free-running shared prescaler
// produces a step strobe every prescale_i+1 clocks; each channel counts steps
// and emits a tick every period+1 steps, in periodic or one-shot mode.
// Ports:
//   clk_i : system clock, rising edge
//   rst_i : synchronous active-high reset, clears all state and outputs
//   bus   : tick_timer_bank_if slave (configuration in, tick/toggle/flag/busy out)
module tick_timer_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 24,
    parameter int PW       = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    tick_timer_bank_if.slave   bus
);

    logic [PW-1:0] pcnt;
    logic          step;

    // >= rather than == so lowering prescale_i below pcnt steps at once
    // instead of wrapping through 2^PW.
    assign step = (pcnt >= bus.prescale_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt <= '0;
        end else if (step) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] period;
        logic             run;
        logic             tick_q;
        logic             toggle_q;
        logic             flag_q;
        logic             en;
        logic             oneshot;
        logic             restart;
        logic             advance;
        logic             hit;

        assign period  = bus.period_i[c*WIDTH +: WIDTH];
        assign en      = bus.enable_i[c];
        assign oneshot = bus.oneshot_i[c];
        // start is meaningful only in one-shot mode and wins over terminal count
        assign restart = en && oneshot && bus.start_i[c];
        assign advance = en && run && step;
        // >= so a period reduced below the running count ticks on the next step
        assign hit     = advance && !restart && (cnt >= period);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt      <= '0;
                run      <= 1'b0;
                tick_q   <= 1'b0;
                toggle_q <= 1'b0;
                flag_q   <= 1'b0;
            end else begin
                if (!en) begin
                    cnt      <= '0;
                    run      <= 1'b0;
                    tick_q   <= 1'b0;
                    toggle_q <= 1'b0;
                end else if (restart) begin
                    cnt    <= '0;
                    run    <= 1'b1;
                    tick_q <= 1'b0;
                end else begin
                    tick_q <= hit;
                    if (hit) begin
                        cnt      <= '0;
                        toggle_q <= ~toggle_q;
                    end else if (advance) begin
                        cnt <= cnt + WIDTH'(1);
                    end
                    // periodic: run follows enable; one-shot: run holds until terminal
                    if (!oneshot) begin
                        run <= 1'b1;
                    end else if (hit) begin
                        run <= 1'b0;
                    end
                end

                // a tick on the same edge as a clear keeps the flag set
                if (hit) begin
                    flag_q <= 1'b1;
                end else if (bus.clear_i[c]) begin
                    flag_q <= 1'b0;
                end
            end
        end

        assign bus.tick_o[c]   = tick_q;
        assign bus.toggle_o[c] = toggle_q;
        assign bus.flag_o[c]   = flag_q;
        assign bus.busy_o[c]   = run;
    end

endmodule
